// File: rtl/p_hit_sched.sv
// rtl/p_hit_sched.sv - per-ray triangle sweep sequencer for p_hit; optional stats via P_HIT_SCHED_STATS_EN
module p_hit_sched #(
  parameter int TRI_ADDR_BITS   = 10,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ray_valid,
  output logic                       ray_ready,
  input  logic signed [31:0]         ray_origin   [2:0],
  input  logic signed [31:0]         ray_dir      [2:0],
  input  logic [TRI_ADDR_BITS-1:0]   ray_tri_base,
  input  logic [TRI_ADDR_BITS:0]     ray_num_tri,
  output logic                       tri_rd_en,
  output logic [TRI_ADDR_BITS-1:0]   tri_rd_addr,
  input  logic signed [31:0]         tri_normal_1 [2:0],
  input  logic signed [31:0]         tri_normal_2 [2:0],
  input  logic signed [31:0]         tri_v0       [2:0],
  output logic signed [31:0]         ph_origin    [2:0],
  output logic signed [31:0]         ph_dir       [2:0],
  output logic signed [31:0]         ph_normal_1  [2:0],
  output logic signed [31:0]         ph_normal_2  [2:0],
  output logic signed [31:0]         ph_v0        [2:0],
  output logic                       ph_in_wr_en,
  input  logic                       ph_in_full,
  input  logic signed [31:0]         ph_out       [2:0],
  input  logic                       ph_out_empty,
  output logic                       ph_out_rd_en,
  output logic                       hit_valid,
  input  logic                       hit_ready,
  output logic signed [31:0]         hit_point    [2:0],
  output logic [TRI_ADDR_BITS-1:0]   hit_tri_idx,
  output logic                       ray_done,
  output logic                       busy
`ifdef P_HIT_SCHED_STATS_EN
  ,
  output logic [31:0]                stat_stall_cycles,
  output logic [31:0]                stat_hits
`endif
);

  localparam int AW = TRI_ADDR_BITS;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_CREDIT = OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q;
  logic [AW:0]   count_q;
  logic [AW:0]   idx_q;
  logic [AW-1:0] res_q;
  logic [OW-1:0] outstanding_q;
  logic          accept;
  logic          can_issue;
  logic          last_issue;

  assign ray_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign tri_rd_addr  = base_q + idx_q[AW-1:0];
  assign can_issue    = !ph_in_full && (outstanding_q < MAX_CREDIT);
  assign last_issue   = ((idx_q + (AW+1)'(1)) == count_q);
  // Results are drained whenever the hit register is empty or being emptied this cycle.
  assign ph_out_rd_en = !ph_out_empty && (!hit_valid || hit_ready);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    tri_rd_en   = 1'b0;
    ph_in_wr_en = 1'b0;
    ray_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ray_valid) begin
          accept  = 1'b1;
          state_d = (ray_num_tri == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        tri_rd_en = 1'b1;
        state_d   = S_LATCH;
      end
      S_LATCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (can_issue) begin
          ph_in_wr_en = 1'b1;
          state_d     = last_issue ? S_DRAIN : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (outstanding_q == '0 && (!hit_valid || hit_ready)) state_d = S_DONE;
      end
      S_DONE: begin
        ray_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ray registers, issue index and triangle holding registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      for (int k = 0; k < 3; k++) begin
        ph_origin[k]   <= '0;
        ph_dir[k]      <= '0;
        ph_normal_1[k] <= '0;
        ph_normal_2[k] <= '0;
        ph_v0[k]       <= '0;
      end
    end else begin
      if (accept) begin
        ph_origin <= ray_origin;
        ph_dir    <= ray_dir;
        base_q    <= ray_tri_base;
        count_q   <= ray_num_tri;
        idx_q     <= '0;
      end
      if (state_q == S_LATCH) begin
        ph_normal_1 <= tri_normal_1;
        ph_normal_2 <= tri_normal_2;
        ph_v0       <= tri_v0;
      end
      if (ph_in_wr_en) idx_q <= idx_q + (AW+1)'(1);
    end
  end

  // Result path: p_hit is in-order, so the tag is simply base plus result count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_q       <= '0;
      hit_valid   <= 1'b0;
      hit_tri_idx <= '0;
      for (int k = 0; k < 3; k++) hit_point[k] <= '0;
    end else begin
      if (accept) begin
        res_q <= '0;
      end else if (ph_out_rd_en) begin
        res_q <= res_q + AW'(1);
      end
      if (ph_out_rd_en) begin
        hit_point   <= ph_out;
        hit_tri_idx <= base_q + res_q;
        hit_valid   <= 1'b1;
      end else if (hit_ready) begin
        hit_valid <= 1'b0;
      end
    end
  end

  // Credit counter for triangles inside p_hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else begin
      case ({ph_in_wr_en, ph_out_rd_en})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

`ifdef P_HIT_SCHED_STATS_EN
  // Per-ray saturating stall and hit counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_stall_cycles <= '0;
      stat_hits         <= '0;
    end else if (accept) begin
      stat_stall_cycles <= '0;
      stat_hits         <= '0;
    end else begin
      if (state_q == S_ISSUE && !can_issue && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (hit_valid && hit_ready && stat_hits != '1)
        stat_hits <= stat_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_p_hit_sched.sv
// tb/tb_p_hit_sched.sv - randomized and directed bench for p_hit_sched
module tb_p_hit_sched;
  localparam int AW   = 10;
  localparam int MAXO = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ray_valid = 1'b0, ray_ready;
  logic signed [31:0] ray_origin [2:0];
  logic signed [31:0] ray_dir [2:0];
  logic [AW-1:0] ray_tri_base = '0;
  logic [AW:0]   ray_num_tri = '0;
  logic tri_rd_en;
  logic [AW-1:0] tri_rd_addr;
  logic signed [31:0] tri_normal_1 [2:0];
  logic signed [31:0] tri_normal_2 [2:0];
  logic signed [31:0] tri_v0 [2:0];
  logic signed [31:0] ph_origin [2:0];
  logic signed [31:0] ph_dir [2:0];
  logic signed [31:0] ph_normal_1 [2:0];
  logic signed [31:0] ph_normal_2 [2:0];
  logic signed [31:0] ph_v0 [2:0];
  logic ph_in_wr_en;
  logic ph_in_full = 1'b0;
  logic signed [31:0] ph_out [2:0];
  logic ph_out_empty = 1'b1;
  logic ph_out_rd_en, hit_valid;
  logic hit_ready = 1'b1;
  logic signed [31:0] hit_point [2:0];
  logic [AW-1:0] hit_tri_idx;
  logic ray_done, busy;
`ifdef P_HIT_SCHED_STATS_EN
  logic [31:0] stat_stall_cycles, stat_hits;
`endif

  p_hit_sched #(.TRI_ADDR_BITS(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir),
    .ray_tri_base(ray_tri_base), .ray_num_tri(ray_num_tri),
    .tri_rd_en(tri_rd_en), .tri_rd_addr(tri_rd_addr),
    .tri_normal_1(tri_normal_1), .tri_normal_2(tri_normal_2), .tri_v0(tri_v0),
    .ph_origin(ph_origin), .ph_dir(ph_dir),
    .ph_normal_1(ph_normal_1), .ph_normal_2(ph_normal_2), .ph_v0(ph_v0),
    .ph_in_wr_en(ph_in_wr_en), .ph_in_full(ph_in_full),
    .ph_out(ph_out), .ph_out_empty(ph_out_empty), .ph_out_rd_en(ph_out_rd_en),
    .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_point(hit_point), .hit_tri_idx(hit_tri_idx),
    .ray_done(ray_done), .busy(busy)
`ifdef P_HIT_SCHED_STATS_EN
    , .stat_stall_cycles(stat_stall_cycles), .stat_hits(stat_hits)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Triangle RAM contents and the p_hit transfer function.
  function automatic logic signed [31:0] tri_val(input int a, input int which, input int k);
    return $signed(32'(a * 256 + which * 16 + k) ^ 32'h5A00_0000);
  endfunction

  function automatic logic signed [31:0] res_val(input int a, input int k,
                                                 input logic signed [31:0] o, input logic signed [31:0] d);
    return tri_val(a, 0, k) + tri_val(a, 1, k) - tri_val(a, 2, k) + (o ^ d);
  endfunction

  typedef struct packed { logic [2:0][31:0] p; int unsigned ready; } ph_ent_t;
  typedef struct packed { logic [2:0][31:0] p; int tag; } hit_ent_t;

  ph_ent_t  phq[$];
  hit_ent_t hitq[$];
  int unsigned cyc = 0;
  int lat = 4;
  logic ram_req = 1'b0;
  int   ram_addr = 0;

  logic m_active, m_hv, m_done_prev, mon_exp_rd;
  int m_base, m_count, m_rd, m_wr, m_rdo, m_hits, m_out;
  int unsigned m_accept_cyc;
  logic signed [31:0] m_org [3];
  logic signed [31:0] m_dir [3];
  int rd_addr_log[$], wr_rel_log[$], tag_log[$];
  int done_rel = -1;
  int rays_done = 0;

  // Models of triangle RAM and the in-order p_hit pipeline, updated after each edge.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (ram_req) begin
      for (int k = 0; k < 3; k++) begin
        tri_normal_1[k] = tri_val(ram_addr, 0, k);
        tri_normal_2[k] = tri_val(ram_addr, 1, k);
        tri_v0[k]       = tri_val(ram_addr, 2, k);
      end
      ram_req = 1'b0;
    end
    if (reset && phq.size() > 0 && phq[0].ready <= cyc) begin
      ph_out_empty = 1'b0;
      for (int k = 0; k < 3; k++) ph_out[k] = $signed(phq[0].p[k]);
    end else begin
      ph_out_empty = 1'b1;
      for (int k = 0; k < 3; k++) ph_out[k] = '0;
    end
  end

  // Single compare process: transaction-level model checked mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      phq.delete(); hitq.delete();
      m_active = 0; m_hv = 0; m_done_prev = 0; m_out = 0;
      m_rd = 0; m_wr = 0; m_rdo = 0; m_hits = 0; ram_req = 0;
    end else begin
      chk("ready_vs_busy", ray_ready, !busy);
      if (m_done_prev) chk("ready_after_done", ray_ready, 1);
      m_done_prev = ray_done;
      mon_exp_rd = !ph_out_empty && (!m_hv || hit_ready);
      chk("ph_out_rd_en", ph_out_rd_en, mon_exp_rd);
      chk("hit_valid", hit_valid, m_hv);
      if (tri_rd_en) begin
        chk("rd_in_range", (m_active && m_rd < m_count), 1);
        chk("tri_rd_addr", tri_rd_addr, (m_base + m_rd) % 1024);
        rd_addr_log.push_back(int'(tri_rd_addr));
        ram_req = 1'b1; ram_addr = int'(tri_rd_addr);
        m_rd++;
      end
      if (ph_in_wr_en) begin
        ph_ent_t e;
        int a;
        a = (m_base + m_wr) % 1024;
        chk("wr_legal", (!ph_in_full && m_out < MAXO && m_wr < m_count), 1);
        for (int k = 0; k < 3; k++) begin
          chk("ph_origin", ph_origin[k], m_org[k]);
          chk("ph_dir", ph_dir[k], m_dir[k]);
          chk("ph_normal_1", ph_normal_1[k], tri_val(a, 0, k));
          chk("ph_normal_2", ph_normal_2[k], tri_val(a, 1, k));
          chk("ph_v0", ph_v0[k], tri_val(a, 2, k));
          e.p[k] = res_val(a, k, m_org[k], m_dir[k]);
        end
        e.ready = cyc + lat;
        if (phq.size() > 0 && phq[$].ready > e.ready) e.ready = phq[$].ready;
        phq.push_back(e);
        wr_rel_log.push_back(int'(cyc - m_accept_cyc));
        m_wr++;
      end
      if (hit_valid && hit_ready) begin
        chk("hit_expected", hitq.size() > 0, 1);
        if (hitq.size() > 0) begin
          hit_ent_t h;
          h = hitq.pop_front();
          for (int k = 0; k < 3; k++) chk("hit_point", hit_point[k], $signed(h.p[k]));
          chk("hit_tri_idx", hit_tri_idx, h.tag);
        end
        tag_log.push_back(int'(hit_tri_idx));
        m_hits++;
      end
      if (ph_out_rd_en && phq.size() > 0) begin
        ph_ent_t e;
        hit_ent_t h;
        e = phq.pop_front();
        h.p = e.p;
        h.tag = (m_base + m_rdo) % 1024;
        hitq.push_back(h);
        m_rdo++;
      end
      if (ray_done) begin
        chk("done_active", m_active, 1);
        chk("done_reads", m_rd, m_count);
        chk("done_writes", m_wr, m_count);
        chk("done_hits", m_hits, m_count);
        chk("done_hitq_empty", hitq.size(), 0);
        chk("done_hv_low", hit_valid, 0);
        m_active = 0;
        done_rel = int'(cyc - m_accept_cyc);
        rays_done++;
      end
      if (ray_valid && ray_ready) begin
        m_active = 1; m_accept_cyc = cyc;
        m_base = int'(ray_tri_base); m_count = int'(ray_num_tri);
        m_rd = 0; m_wr = 0; m_rdo = 0; m_hits = 0;
        for (int k = 0; k < 3; k++) begin m_org[k] = ray_origin[k]; m_dir[k] = ray_dir[k]; end
        rd_addr_log.delete(); wr_rel_log.delete(); tag_log.delete(); done_rel = -1;
      end
      m_out = m_out + int'(ph_in_wr_en) - int'(ph_out_rd_en);
      m_hv = mon_exp_rd ? 1'b1 : (hit_ready ? 1'b0 : m_hv);
    end
  end

  int  full_pct = 0, ready_pct = 100;
  logic manual = 1'b0;

  task automatic tick();
    @(posedge clock); #1;
    if (!manual) begin
      ph_in_full = (int'($urandom_range(99)) < full_pct);
      hit_ready  = (int'($urandom_range(99)) < ready_pct);
    end
  endtask

  task automatic start_ray(input int base, input int cnt);
    int n = 0;
    while (!ray_ready && n < 100) begin tick(); n++; end
    chk("idle_before_ray", ray_ready, 1);
    ray_tri_base = AW'(base);
    ray_num_tri  = (AW+1)'(cnt);
    for (int k = 0; k < 3; k++) begin ray_origin[k] = $urandom; ray_dir[k] = $urandom; end
    ray_valid = 1'b1;
    tick();
    ray_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start = rays_done;
    int n = 0;
    while (rays_done == start && n < bound) begin tick(); n++; end
    chk("ray_completed", rays_done != start, 1);
  endtask

  task automatic run_ray(input int base, input int cnt, input int l, input int fp, input int rp);
    lat = l; full_pct = fp; ready_pct = rp;
    start_ray(base, cnt);
    wait_done(200 + cnt * 60);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ray_ready", ray_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tri_rd_en", tri_rd_en, 0);
    chk("rst_tri_rd_addr", tri_rd_addr, 0);
    chk("rst_ph_in_wr_en", ph_in_wr_en, 0);
    chk("rst_ph_out_rd_en", ph_out_rd_en, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_tri_idx", hit_tri_idx, 0);
    chk("rst_ray_done", ray_done, 0);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ph_origin", ph_origin[k], 0);
      chk("rst_ph_dir", ph_dir[k], 0);
      chk("rst_ph_normal_1", ph_normal_1[k], 0);
      chk("rst_ph_normal_2", ph_normal_2[k], 0);
      chk("rst_ph_v0", ph_v0[k], 0);
      chk("rst_hit_point", hit_point[k], 0);
    end
`ifdef P_HIT_SCHED_STATS_EN
    chk("rst_stat_stall", stat_stall_cycles, 0);
    chk("rst_stat_hits", stat_hits, 0);
`endif
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ray_origin[k] = '0; ray_dir[k] = '0; ph_out[k] = '0;
      tri_normal_1[k] = '0; tri_normal_2[k] = '0; tri_v0[k] = '0;
    end
    manual = 1'b1;
    tick(); tick();
    chk_reset_outputs();
    reset = 1'b1;
    tick();

    // Base 5, three triangles, latency 4, no back-pressure.
    manual = 1'b0;
    run_ray(5, 3, 4, 0, 100);
    chk("t1_rd_n", rd_addr_log.size(), 3);
    chk("t1_wr_n", wr_rel_log.size(), 3);
    chk("t1_tag_n", tag_log.size(), 3);
    for (int j = 0; j < 3; j++) begin
      chk("t1_rd_addr", rd_addr_log[j], 5 + j);
      chk("t1_wr_cycle", wr_rel_log[j], 3 + 3 * j);
      chk("t1_tag", tag_log[j], 5 + j);
    end
    chk("t1_done_cycle", done_rel, 15);

    // Empty ray.
    run_ray(77, 0, 4, 0, 100);
    chk("t2_rd_n", rd_addr_log.size(), 0);
    chk("t2_wr_n", wr_rel_log.size(), 0);
    chk("t2_tag_n", tag_log.size(), 0);
    chk("t2_done_cycle", done_rel, 1);

    // Address wrap.
    run_ray(1022, 4, 3, 0, 100);
    chk("t4_rd_n", rd_addr_log.size(), 4);
    chk("t4_tag_n", tag_log.size(), 4);
    for (int j = 0; j < 4; j++) begin
      chk("t4_rd_addr", rd_addr_log[j], (1022 + j) % 1024);
      chk("t4_tag", tag_log[j], (1022 + j) % 1024);
    end

    // Input FIFO full for five ISSUE cycles on the first triangle.
    manual = 1'b1; ph_in_full = 1'b0; hit_ready = 1'b1; lat = 4;
    start_ray(200, 2);
    tick();
    ph_in_full = 1'b1;
    for (int r = 3; r <= 7; r++) begin
      tick(); #1;
      chk("t5_blocked", ph_in_wr_en, 0);
      chk("t5_operand_stable", ph_normal_1[1], tri_val(200, 0, 1));
    end
    tick();
    ph_in_full = 1'b0;
    #1;
    chk("t5_write_on_release", ph_in_wr_en, 1);
    wait_done(200);
    chk("t5_first_wr", wr_rel_log[0], 8);
    chk("t5_second_wr", wr_rel_log[1], 11);
`ifdef P_HIT_SCHED_STATS_EN
    chk("t5_stat_stall", stat_stall_cycles, 5);
    chk("t5_stat_hits", stat_hits, 2);
`endif

    // Credit limit of 2 with the hit consumer stalled.
    hit_ready = 1'b0; ph_in_full = 1'b0; lat = 22;
    start_ray(100, 4);
    for (int r = 2; r <= 20; r++) begin
      tick(); #1;
      if (r >= 9) begin
        chk("t3_credit_hold", ph_in_wr_en, 0);
        chk("t3_operand_stable", ph_v0[0], tri_val(102, 2, 0));
      end
    end
    chk("t3_writes_held", wr_rel_log.size(), 2);
    hit_ready = 1'b1;
    wait_done(400);
    chk("t3_tag_n", tag_log.size(), 4);
    for (int j = 0; j < 4; j++) chk("t3_tag", tag_log[j], 100 + j);

    // Asynchronous reset in the middle of DRAIN.
    lat = 4; hit_ready = 1'b1; ph_in_full = 1'b0;
    start_ray(300, 3);
    repeat (10) tick();
    chk("t6_in_drain_busy", busy, 1);
    #2;
    reset = 1'b0;
    ph_out_empty = 1'b1;
    #1;
    chk_reset_outputs();
    tick(); tick();
    reset = 1'b1;
    manual = 1'b0;
    run_ray(300, 3, 4, 0, 100);
    chk("t6_tag_n", tag_log.size(), 3);
    for (int j = 0; j < 3; j++) chk("t6_tag", tag_log[j], 300 + j);
    chk("t6_done_cycle", done_rel, 15);

    // Randomized rays with back-pressure on both sides.
    for (int n = 0; n < 30; n++) begin
      int cnt;
      cnt = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 12));
      run_ray(int'($urandom_range(1023)), cnt, int'($urandom_range(1, 12)),
              int'($urandom_range(50)), int'($urandom_range(20, 100)));
    end

    // Full-range triangle count.
    run_ray(513, 1024, 2, 10, 90);
    chk("big_tag_n", tag_log.size(), 1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/p_hit_sched.md
# p_hit_sched

Per-ray triangle sweep sequencer for the `p_hit` hit-point datapath. It accepts one ray at a time and reads the ray's triangle range from triangle RAM. It issues one `{normals, v0, origin, dir}` set per triangle into the `p_hit` input FIFOs under a credit limit. It drains the `p_hit` output FIFO into a tagged hit stream and signals completion once every issued triangle has returned and been consumed.

## Interface
- `TRI_ADDR_BITS`, 10, triangle RAM address width.
- `MAX_OUTSTANDING`, 8, maximum triangles in flight inside `p_hit` (1..255).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ray_valid`  in  1  ray request.
- `ray_ready`  out  1  high only in IDLE.
- `ray_origin[2:0]`  in  32 signed each  Q10 origin.
- `ray_dir[2:0]`  in  32 signed each  Q10 direction.
- `ray_tri_base`  in  TRI_ADDR_BITS  first triangle address.
- `ray_num_tri`  in  TRI_ADDR_BITS+1  triangle count, 0..2^TRI_ADDR_BITS.
- `tri_rd_en`  out  1  RAM read strobe.
- `tri_rd_addr`  out  TRI_ADDR_BITS  RAM address.
- `tri_normal_1[2:0]`, `tri_normal_2[2:0]`, `tri_v0[2:0]`  in  32 signed each  RAM data, valid the cycle after `tri_rd_en`.
- `ph_origin[2:0]`, `ph_dir[2:0]`, `ph_normal_1[2:0]`, `ph_normal_2[2:0]`, `ph_v0[2:0]`  out  32 signed each  `p_hit` operands.
- `ph_in_wr_en`  out  1  write strobe to all `p_hit` input FIFOs together.
- `ph_in_full`  in  1  OR of all `p_hit` input FIFO fulls.
- `ph_out[2:0]`  in  32 signed each  `p_hit` result, show-ahead (valid while `!ph_out_empty`).
- `ph_out_empty`  in  1.
- `ph_out_rd_en`  out  1.
- `hit_valid`  out  1.
- `hit_ready`  in  1.
- `hit_point[2:0]`  out  32 signed each.
- `hit_tri_idx`  out  TRI_ADDR_BITS  RAM address of the triangle that produced the result.
- `ray_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, FETCH, LATCH, ISSUE, DRAIN, DONE.
- IDLE: on `ray_valid && ray_ready`:
  - register origin, dir, base and count; clear issue index `i` and result index `r`.
  - If count==0, go to DONE; otherwise go to FETCH.
- FETCH: `tri_rd_en`=1, `tri_rd_addr`=base+i (mod 2^TRI_ADDR_BITS, wraps). Go to LATCH.
- LATCH: capture RAM data into holding registers. Go to ISSUE.
- ISSUE: pulse `ph_in_wr_en` when `!ph_in_full && outstanding < MAX_OUTSTANDING`; otherwise hold with operands stable.
  - On write, i++. If i==count, go to DRAIN; otherwise go to FETCH.
- DRAIN: wait until `outstanding==0` and (`!hit_valid` or `hit_ready`). Go to DONE.
- DONE: `ray_done`=1 for one cycle. Go to IDLE.
- `ph_origin`/`ph_dir` equal the registered ray values for the whole ray.
- Result path runs independently of the FSM:
  - `ph_out_rd_en` = `!ph_out_empty && (!hit_valid || hit_ready)`.
  - On a read: load `hit_point` from `ph_out`, set `hit_tri_idx` = base+r, r++, set `hit_valid` next cycle.
  - `hit_valid` clears on `hit_ready` with no new read.
- `outstanding` rules:
  - +1 on `ph_in_wr_en`, -1 on `ph_out_rd_en`, unchanged when both occur in the same cycle.
  - Width is ceil(log2(MAX_OUTSTANDING+1)).
- The result path relies on `p_hit` being in-order; tags come from the result order alone.
- Reset (asynchronous, mid-ray included): FSM to IDLE, all counters and holding registers zero, in-flight `p_hit` results discarded.

## Timing
- Reset values: `ray_ready`=1, `busy`=0. Every other output is 0, including all operand, hit and address buses.
- Accept at edge 0; `tri_rd_en` in cycle 1; first `ph_in_wr_en` in cycle 3 if unstalled.
- Unstalled throughput is one triangle per 3 cycles.
- `hit_valid` rises the cycle after `ph_out_rd_en`; a hit is transferred on `hit_valid && hit_ready`.
- `ray_done` asserts no earlier than the cycle after the last hit transfer. `ray_ready` returns the cycle after `ray_done`.
- count==0: `ray_done` in cycle 1 after accept, no RAM reads, no writes.

## Configuration
- `P_HIT_SCHED_STATS_EN` defined:
  - adds outputs `stat_stall_cycles` (32) and `stat_hits` (32), both cleared on ray accept and saturating at all-ones.
  - `stat_stall_cycles` counts ISSUE cycles blocked by full or credit.
  - `stat_hits` counts hit transfers.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Base=5, count=3, `ph_in_full`=0, `hit_ready`=1, model `p_hit` latency 4 → reads at addresses 5, 6, 7; writes in cycles 3, 6, 9; hits tagged 5, 6, 7 in order; single `ray_done`; `ray_ready` high again.
- count=0 → `ray_done` in cycle 1, `tri_rd_en` never asserted, no hits.
- MAX_OUTSTANDING=2, `hit_ready`=0 for 20 cycles, count=4 → exactly 2 writes, then ISSUE holds with stable operands; releasing `hit_ready` completes all 4 in order.
- Base=1022, count=4, TRI_ADDR_BITS=10 → addresses 1022, 1023, 0, 1; tags match.
- `ph_in_full` held high for 5 cycles during the first ISSUE → no write, operands stable, write on the first not-full cycle. With the macro defined, `stat_stall_cycles`=5.
- Assert `reset` low mid-DRAIN → all outputs at reset values asynchronously; a new ray runs cleanly after release.
